// File: rtl/lfsr_8_pkg.sv
// Shared definitions for the 8-bit-period LFSR stream checker: FSM states,
// reference period, predictor feedback and error-counter sizing.
package lfsr_8_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // One full period of the generator's X2 stream, first bit in the MSB.
  localparam logic [7:0] PERIOD = 8'b10111000;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  localparam logic [2:0] PRED_RESET = 3'b100;

  // Next X2 from state {X2,X1,X0}.
  function automatic logic fb(input logic [2:0] s);
    return (~(s[2] | s[1])) ^ s[1] ^ s[0];
  endfunction

endpackage

// File: rtl/lfsr_8_pred.sv
// Local copy of the generator: seeded from a received window, then advanced
// only with its own predictions so line errors never corrupt it.
module lfsr_8_pred
  import lfsr_8_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       seed_en,
  input  logic [2:0] seed_val,
  input  logic       adv_en,
  output logic       pred_bit
);

  logic [2:0] pred_q;
  logic [2:0] pred_d;

  always_comb begin
    pred_d = pred_q;
    if (seed_en) begin
      pred_d = seed_val;
    end else if (adv_en) begin
      pred_d = {fb(pred_q), pred_q[2:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pred_q <= PRED_RESET;
    end else begin
      pred_q <= pred_d;
    end
  end

  assign pred_bit = fb(pred_q);

endmodule

// File: rtl/lfsr_8_checker.sv
// Serial checker for the 8-bit-period LFSR stream: hunts for a 3-bit seed
// window, verifies LOCK_CNT predictions, then counts errors while locked.
module lfsr_8_checker
  import lfsr_8_pkg::*;
#(
  parameter int LOCK_CNT  = 8,
  parameter int LOSS_ERRS = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 DIN,
  input  logic                 DIN_VALID,
  input  logic                 ERR_CLR,
  output logic                 LOCK,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_ERRS - 1);

  state_e                 state_q, state_d;
  logic [1:0]             fill_q, fill_d;
  logic [1:0]             win_q, win_d;
  logic [7:0]             good_q, good_d;
  logic [3:0]             consec_q, consec_d;
  logic                   lock_q, lock_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   seed_en;
  logic                   adv_en;
  logic [2:0]             seed_val;
  logic                   pred_bit;
  logic                   mismatch;
  logic                   err_hit;

  lfsr_8_pred u_pred (
    .CLK      (CLK),
    .RESET    (RESET),
    .seed_en  (seed_en),
    .seed_val (seed_val),
    .adv_en   (adv_en),
    .pred_bit (pred_bit)
  );

  assign mismatch = DIN ^ pred_bit;
  // win_q[0] is the previous bit, win_q[1] the one before it.
  assign seed_val = {DIN, win_q[0], win_q[1]};

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    win_d     = win_q;
    good_d    = good_q;
    consec_d  = consec_q;
    err_d     = 1'b0;
    err_hit   = 1'b0;
    seed_en   = 1'b0;
    adv_en    = 1'b0;

    if (DIN_VALID) begin
      unique case (state_q)
        ST_HUNT: begin
          win_d = {win_q[0], DIN};
          if (fill_q == 2'd2) begin
            seed_en = 1'b1;
            fill_d  = 2'd0;
            good_d  = 8'd0;
            state_d = ST_VERIFY;
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end
        ST_VERIFY: begin
          adv_en = 1'b1;
          if (mismatch) begin
            state_d = ST_HUNT;
            fill_d  = 2'd0;
          end else if (good_q == LOCK_LAST) begin
            state_d  = ST_LOCKED;
            good_d   = 8'd0;
            consec_d = 4'd0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        ST_LOCKED: begin
          adv_en = 1'b1;
          if (mismatch) begin
            err_d   = 1'b1;
            err_hit = 1'b1;
            if (consec_q == LOSS_LAST) begin
              state_d  = ST_HUNT;
              fill_d   = 2'd0;
              consec_d = 4'd0;
            end else begin
              consec_d = consec_q + 4'd1;
            end
          end else begin
            consec_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = 2'd0;
        end
      endcase
    end

    // A clear coinciding with a counted error leaves that error recorded.
    err_cnt_d = err_cnt_q;
    if (ERR_CLR) begin
      err_cnt_d = err_hit ? ERR_CNT_W'(1) : '0;
    end else if (err_hit && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_HUNT;
      fill_q    <= 2'd0;
      good_q    <= 8'd0;
      consec_q  <= 4'd0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      consec_q  <= consec_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Window bits are pure data; the fill count decides when they are used.
  always_ff @(posedge CLK) begin
    win_q <= win_d;
  end

  assign LOCK    = lock_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_lfsr_8_checker.sv
// Randomised scoreboard bench for lfsr_8_checker against a period-table model.
module tb_lfsr_8_checker;

  localparam int LOCK_CNT  = 8;
  localparam int LOSS_ERRS = 3;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       err_clr;
  logic       lock;
  logic       err;
  logic [7:0] err_cnt;

  lfsr_8_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_ERRS(LOSS_ERRS)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .DIN       (din),
    .DIN_VALID (din_valid),
    .ERR_CLR   (err_clr),
    .LOCK      (lock),
    .ERR       (err),
    .ERR_CNT   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       lock;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference period, first bit first.
  bit seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Behavioural model: 0 = hunt, 1 = verify, 2 = locked.
  int mode = 0, fill = 0, good = 0, consec = 0, errcnt = 0, nxt = 0;
  bit h1 = 0, h2 = 0;   // h1 previous valid bit, h2 the one before it
  bit m_lock = 0;
  int gen_ph = 0;       // phase of the clean transmitter stream

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit d, input bit v, input bit c);
    bit hit, m_err, expb;
    int p;
    hit = 0;
    m_err = 0;
    if (r) begin
      mode = 0; fill = 0; good = 0; consec = 0; errcnt = 0;
    end else begin
      if (v) begin
        case (mode)
          0: begin
            if (fill == 2) begin
              p = -1;
              for (int k = 0; k < 8; k++)
                if (seq[k] == h2 && seq[(k+1)%8] == h1 && seq[(k+2)%8] == d) p = k;
              nxt = (p < 0) ? 0 : (p + 3) % 8;
              mode = 1; good = 0; fill = 0;
            end else begin
              fill++;
            end
            h2 = h1;
            h1 = d;
          end
          1: begin
            expb = seq[nxt];
            nxt = (nxt + 1) % 8;
            if (d != expb) begin
              mode = 0; fill = 0;
            end else begin
              good++;
              if (good == LOCK_CNT) begin mode = 2; good = 0; consec = 0; end
            end
          end
          default: begin
            expb = seq[nxt];
            nxt = (nxt + 1) % 8;
            if (d != expb) begin
              hit = 1; m_err = 1; consec++;
              if (consec == LOSS_ERRS) begin mode = 0; fill = 0; consec = 0; end
            end else begin
              consec = 0;
            end
          end
        endcase
      end
      if (c) errcnt = hit ? 1 : 0;
      else if (hit && errcnt < 255) errcnt++;
    end
    m_lock = (mode == 2);
    exp_q.push_back('{lock: m_lock, err: m_err, cnt: 8'(errcnt)});
  endtask

  task automatic drive(input bit r, input bit d, input bit v, input bit c);
    @(negedge clk);
    rst = r; din = d; din_valid = v; err_clr = c;
    model_step(r, d, v, c);
  endtask

  // One cycle of the transmitter: a valid bit (optionally inverted) or an idle gap.
  task automatic tx(input bit v, input bit flip, input bit c);
    bit d;
    if (v) begin
      d = seq[gen_ph] ^ flip;
      gen_ph = (gen_ph + 1) % 8;
    end else begin
      d = 1'($urandom);
    end
    drive(1'b0, d, v, c);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) tx(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented output against the head of the scoreboard.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lock", int'(lock), int'(e.lock));
      chk("err", int'(err), int'(e.err));
      chk("err_cnt", int'(err_cnt), int'(e.cnt));
    end
  end

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; err_clr = 1'b0;

    // Clean stream from phase 0, valid every cycle.
    do_reset(2);
    gen_ph = 0;
    clean(24);

    // Phase 5 (000101110...) with valid toggling.
    do_reset(1);
    gen_ph = 5;
    for (int i = 0; i < 40; i++) tx(1'(i % 2 == 0), 1'b0, 1'b0);

    // Single inverted bit while locked.
    tx(1'b1, 1'b1, 1'b0);
    clean(16);

    // Three consecutive inversions lose lock, then relock.
    for (int i = 0; i < 3; i++) tx(1'b1, 1'b1, 1'b0);
    clean(20);

    // Random bits drive ERR_CNT into saturation.
    for (int i = 0; i < 300; i++) drive(1'b0, 1'($urandom), 1'b1, 1'b0);
    clean(24);
    tx(1'b1, 1'b1, 1'b0);
    clean(3);
    tx(1'b1, 1'b1, 1'b1);
    clean(6);
    tx(1'b1, 1'b0, 1'b1);
    clean(4);

    // Five isolated errors, then reset mid-lock and relock.
    for (int i = 0; i < 5; i++) begin
      tx(1'b1, 1'b1, 1'b0);
      clean(2);
    end
    do_reset(1);
    clean(14);

    // Long random mix of gaps, rare inversions, clears and resets.
    for (int i = 0; i < 2500; i++) begin
      int rr;
      rr = int'($urandom_range(0, 999));
      if (rr < 3) do_reset(1);
      else tx(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 49) == 0));
    end

    // Clear with no valid bits outstanding.
    tx(1'b0, 1'b0, 1'b1);
    clean(4);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
